issue_rat_redeem_fifo: RTL
==========================

Name: issue_rat_redeem_fifo

Overview:
Buffers physical registers released at commit and feeds them, one per cycle, to the RAT freelist redeem port over a valid/ready handshake. Commit can release up to two PRFs per cycle, but the freelist accepts one per cycle, so this FIFO absorbs the rate mismatch. It sits directly upstream of issue_rat_freelist: o_redeemed_* connects to the freelist's i_redeemed_*/o_redeemed_ready. It preserves release order and never drops an accepted PRF.

Parameters:
PRF_WIDTH, 6, width of a physical register index.
DEPTH, 8, entry count; power of two, at least 4.

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  asynchronous active-low reset
i_release0_prf  input  PRF_WIDTH  first (older) released PRF this cycle
i_release0_valid  input  1  slot 0 carries a PRF
i_release1_prf  input  PRF_WIDTH  second (younger) released PRF this cycle
i_release1_valid  input  1  slot 1 carries a PRF
o_release_ready  output  1  FIFO can accept two PRFs this cycle
o_redeemed_prf  output  PRF_WIDTH  head PRF toward the freelist
o_redeemed_valid  output  1  head entry valid
i_redeemed_ready  input  1  freelist accepts the head this cycle
o_count  output  $clog2(DEPTH)+1  occupied entries
o_empty  output  1  count == 0

Behaviour:
- Reset (resetn low, asynchronous): rd_ptr=0, wr_ptr=0, count=0. Outputs: o_redeemed_valid=0, o_redeemed_prf=0, o_release_ready=1, o_count=0, o_empty=1. Storage array is not reset.
- Reset mid-operation discards all buffered entries immediately. Checkpoint restore is the owner's responsibility and is outside this block.
- o_release_ready = (DEPTH - count) >= 2. It is a function of registered count only; no combinational path from any input.
- Enqueue fires only when o_release_ready=1. Slot valids asserted while not ready are ignored and are a protocol violation; the bench flags them.
- Enqueue order within a cycle: slot 0 goes before slot 1.
  - Both valid: mem[wr_ptr]=prf0, mem[wr_ptr+1]=prf1, wr_ptr+=2.
  - Only slot 0 valid: write prf0, wr_ptr+=1.
  - Only slot 1 valid: prf1 is written at wr_ptr and wr_ptr+=1, with no hole.
- Dequeue fires when o_redeemed_valid && i_redeemed_ready. It advances rd_ptr by 1.
- Output is first-word-fallthrough from storage:
  - o_redeemed_valid = (count != 0).
  - o_redeemed_prf = mem[rd_ptr] when valid, else 0.
- Latency: a PRF enqueued at edge N is visible on o_redeemed_* in the cycle after edge N when the FIFO was empty. Minimum release-to-freelist latency is 1 cycle.
- Count update: count_next = count + n_enq - n_deq, with n_enq in {0,1,2} and n_deq in {0,1}.
- Simultaneous enqueue and dequeue are legal in all states, including empty and near-full.
  - Empty: dequeue cannot fire because valid=0. A same-cycle enqueue is never bypassed combinationally.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. A two-entry write straddling the wrap (wr_ptr=DEPTH-1) writes DEPTH-1 and 0.
- Full/near-full:
  - count = DEPTH-1 or DEPTH gives o_release_ready=0.
  - count never exceeds DEPTH (invariant; assert in sim).
- Backpressure: i_redeemed_ready low holds o_redeemed_prf/valid stable until accepted.
- Ordering invariant: PRFs leave in exact acceptance order. No duplication, no loss.

Decomposition:
- Shared issue package holds PRF_WIDTH and the PRF index typedef. issue_rat_freelist uses the same ones.
- One sub-module is natural: issue_rat_redeem_fifo_mem, a DEPTH x PRF_WIDTH storage array with 2 write ports and 1 async read port, no reset.
- Pointer and count control stays in the top module.

Test Plan:
- Reset: hold resetn=0 then release -> o_redeemed_valid=0, o_release_ready=1, o_count=0, o_empty=1.
- Single release: release0=0x21 valid and i_redeemed_ready=1 -> next cycle o_redeemed_prf=0x21, valid=1; one cycle later count=0.
- Dual release, ready held low:
  - Cycle 1: {0x05,0x06}. Cycle 2: {0x07,0x08}.
  - Expect count=4 and head=0x05.
  - Raise ready -> outputs 0x05, 0x06, 0x07, 0x08 on consecutive cycles.
- Slot1-only release: release1=0x3F only -> stored with no hole; head=0x3F next cycle.
- Fill with ready low:
  - 3 dual releases -> count=6, o_release_ready=1.
  - 4th dual release -> count=8, o_release_ready=0.
  - Further valids ignored, count stays 8.
  - One dequeue -> count=7, ready stays 0.
  - Second dequeue -> count=6, ready=1.
- Wrap plus simultaneous traffic: drive wr_ptr to 7, then enqueue {0x11,0x12} while dequeuing -> entries land at 7 and 0, count +1, order preserved across 20 random cycles vs scoreboard.

Source files
------------

// File: rtl/issue_rat_redeem_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : issue_rat_redeem_fifo_pkg
// Purpose : Shared issue-stage definitions: PRF index width, PRF index type
//           and a small helper used by the redeem FIFO.
// Revision: 1.0 - initial release
// ============================================================================
package issue_rat_redeem_fifo_pkg;

    // Physical register index width, shared with issue_rat_freelist
    localparam int PRF_WIDTH = 6;

    typedef logic [PRF_WIDTH-1:0] prf_t;

    // Number of entries written this cycle by the two write ports
    function automatic logic [1:0] enq_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_rat_redeem_fifo_if.sv
`default_nettype none
// ============================================================================
// Module  : issue_rat_redeem_fifo_if
// Purpose : Commit-release and freelist-redeem handshake bundle for the
//           redeem FIFO. master = environment, slave = FIFO.
// Revision: 1.0 - initial release
// ============================================================================
interface issue_rat_redeem_fifo_if #(
    parameter int PRF_WIDTH = issue_rat_redeem_fifo_pkg::PRF_WIDTH,
    parameter int DEPTH     = 8
);
    logic [PRF_WIDTH-1:0]     i_release0_prf;
    logic                     i_release0_valid;
    logic [PRF_WIDTH-1:0]     i_release1_prf;
    logic                     i_release1_valid;
    logic                     o_release_ready;
    logic [PRF_WIDTH-1:0]     o_redeemed_prf;
    logic                     o_redeemed_valid;
    logic                     i_redeemed_ready;
    logic [$clog2(DEPTH):0]   o_count;
    logic                     o_empty;

    modport master (
        output i_release0_prf, i_release0_valid,
        output i_release1_prf, i_release1_valid,
        output i_redeemed_ready,
        input  o_release_ready, o_redeemed_prf, o_redeemed_valid,
        input  o_count, o_empty
    );

    modport slave (
        input  i_release0_prf, i_release0_valid,
        input  i_release1_prf, i_release1_valid,
        input  i_redeemed_ready,
        output o_release_ready, o_redeemed_prf, o_redeemed_valid,
        output o_count, o_empty
    );
endinterface
`default_nettype wire

// File: rtl/issue_rat_redeem_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module  : issue_rat_redeem_fifo_mem
// Purpose : DEPTH x PRF_WIDTH storage, two write ports, one asynchronous
//           read port. Contents are not reset.
// Revision: 1.0 - initial release
// ============================================================================
module issue_rat_redeem_fifo_mem #(
    parameter int PRF_WIDTH = 6,
    parameter int DEPTH     = 8
) (
    input  wire logic                       clk,
    input  wire logic                       i_wa_en,
    input  wire logic [$clog2(DEPTH)-1:0]   i_wa_addr,
    input  wire logic [PRF_WIDTH-1:0]       i_wa_data,
    input  wire logic                       i_wb_en,
    input  wire logic [$clog2(DEPTH)-1:0]   i_wb_addr,
    input  wire logic [PRF_WIDTH-1:0]       i_wb_data,
    input  wire logic [$clog2(DEPTH)-1:0]   i_rd_addr,
    output logic      [PRF_WIDTH-1:0]       o_rd_data
);
    logic [PRF_WIDTH-1:0] r_mem [DEPTH];

    // Write both ports; the controller never enables both on one address
    always_ff @(posedge clk) begin
        if (i_wa_en) r_mem[i_wa_addr] <= i_wa_data;
        if (i_wb_en) r_mem[i_wb_addr] <= i_wb_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule
`default_nettype wire

// File: rtl/issue_rat_redeem_fifo.sv
`default_nettype none
// ============================================================================
// Module  : issue_rat_redeem_fifo
// Purpose : Absorbs up to two released PRFs per cycle from commit and feeds
//           them in order, one per cycle, to the freelist redeem port
//           (first-word-fallthrough, no same-cycle bypass).
// Revision: 1.0 - initial release
// ============================================================================
module issue_rat_redeem_fifo #(
    parameter int PRF_WIDTH = issue_rat_redeem_fifo_pkg::PRF_WIDTH,
    parameter int DEPTH     = 8
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    issue_rat_redeem_fifo_if.slave  bus
);
    import issue_rat_redeem_fifo_pkg::*;

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_release_ready;
    logic                 w_wa_en;
    logic                 w_wb_en;
    logic [PRF_WIDTH-1:0] w_wa_data;
    logic [c_PTR_W-1:0]   w_wb_addr;
    logic [1:0]           w_n_enq;
    logic                 w_valid;
    logic                 w_deq;
    logic [PRF_WIDTH-1:0] w_rd_data;

    // Ready depends only on registered count: room for a full dual release
    assign w_release_ready = (r_count <= c_CNT_W'(DEPTH - 2));

    // Port A takes the oldest valid slot so a lone slot-1 PRF leaves no hole
    assign w_wa_en   = w_release_ready & (bus.i_release0_valid | bus.i_release1_valid);
    assign w_wb_en   = w_release_ready & bus.i_release0_valid & bus.i_release1_valid;
    assign w_wa_data = bus.i_release0_valid ? bus.i_release0_prf : bus.i_release1_prf;
    assign w_wb_addr = r_wr_ptr + c_PTR_W'(1);
    assign w_n_enq   = enq_count(w_wa_en, w_wb_en);

    assign w_valid = (r_count != '0);
    assign w_deq   = w_valid & bus.i_redeemed_ready;

    issue_rat_redeem_fifo_mem #(
        .PRF_WIDTH (PRF_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wa_en   (w_wa_en),
        .i_wa_addr (r_wr_ptr),
        .i_wa_data (w_wa_data),
        .i_wb_en   (w_wb_en),
        .i_wb_addr (w_wb_addr),
        .i_wb_data (bus.i_release1_prf),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Pointer and occupancy update; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_n_enq);
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_deq);
            r_count  <= r_count + c_CNT_W'(w_n_enq) - c_CNT_W'(w_deq);
        end
    end

    assign bus.o_release_ready  = w_release_ready;
    assign bus.o_redeemed_valid = w_valid;
    assign bus.o_redeemed_prf   = w_valid ? w_rd_data : '0;
    assign bus.o_count          = r_count;
    assign bus.o_empty          = ~w_valid;

    // Occupancy can never exceed the storage size
    a_count_bound : assert property (@(posedge clk) disable iff (!resetn)
        r_count <= c_CNT_W'(DEPTH));
endmodule
`default_nettype wire
